alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_op_sequencer.sv | 111 +++++++++++
 tb/tb_alu_op_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states,
// flag bit positions and the opcode legality rule.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 6;
  localparam int TAG_W  = 4;
  localparam int FLAG_W = 4;

  localparam logic [OP_W-1:0] OP_PASS_A = 6'h00;
  localparam logic [OP_W-1:0] OP_PASS_B = 6'h01;
  localparam logic [OP_W-1:0] OP_AND    = 6'h02;
  localparam logic [OP_W-1:0] OP_OR     = 6'h03;
  localparam logic [OP_W-1:0] OP_XOR    = 6'h04;
  localparam logic [OP_W-1:0] OP_NOT_A  = 6'h05;
  localparam logic [OP_W-1:0] OP_ADD    = 6'h06;
  localparam logic [OP_W-1:0] OP_SUB    = 6'h07;
  localparam logic [OP_W-1:0] OP_SLL    = 6'h08;
  localparam logic [OP_W-1:0] OP_SRL    = 6'h09;
  localparam logic [OP_W-1:0] OP_SRA    = 6'h0A;
  localparam logic [OP_W-1:0] OP_SLT    = 6'h0B;
  localparam logic [OP_W-1:0] OP_SLTU   = 6'h0C;
  localparam logic [OP_W-1:0] OP_ADDU   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LAST   = OP_ADDU;

  // rsp_flags is packed {Z,N,C,V}
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Accepts one ALU command at a time, holds the operands on the ALU for a
// settle window, captures result and flags, and returns a tagged response.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_op,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_c,
  input  logic              alu_v,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              rsp_err,
  output logic [TAG_W-1:0]  rsp_tag,
  output state_t            state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1. cmd_ready is 1 only in IDLE, rsp_valid only in RESP, and the
  // response fields hold steady for as long as rsp_valid waits on rsp_ready.

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [3:0]       settle_cnt;
  logic [TAG_W-1:0] tag_cnt;
  logic             accept;

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_data   <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      rsp_tag    <= '0;
      tag_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready <= 1'b0;
            rsp_tag   <= tag_cnt;
            tag_cnt   <= tag_cnt + 4'd1;
            if (op_is_legal(cmd_op)) begin
              alu_a      <= cmd_a;
              alu_b      <= cmd_b;
              alu_op     <= 32'(cmd_op);
              settle_cnt <= '0;
              state      <= DRIVE;
            end else begin
              // Illegal opcodes never touch the ALU; answer straight away.
              rsp_data  <= '0;
              rsp_flags <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= CAPTURE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        CAPTURE: begin
          rsp_data          <= alu_res;
          rsp_flags[FLAG_Z] <= alu_z;
          rsp_flags[FLAG_N] <= alu_n;
          rsp_flags[FLAG_C] <= alu_c;
          rsp_flags[FLAG_V] <= alu_v;
          rsp_err           <= 1'b0;
          rsp_valid         <= 1'b1;
          state             <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU drives the DUT's ALU inputs,
// and responses are scored against a spec-level model of result, flags and tag.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT with SETTLE_CYCLES=1 ----------------
  logic        rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [5:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b, alu_a, alu_b, alu_op, alu_res, rsp_data;
  logic        alu_z, alu_n, alu_c, alu_v;
  logic [3:0]  rsp_flags, rsp_tag;
  state_t      state;
  logic [35:0] alu_out;

  // ---------------- DUT with SETTLE_CYCLES=4 ----------------
  logic        rst_n_s4, cmd_valid_s4, cmd_ready_s4, rsp_valid_s4, rsp_ready_s4, rsp_err_s4;
  logic [5:0]  cmd_op_s4;
  logic [31:0] cmd_a_s4, cmd_b_s4, alu_a_s4, alu_b_s4, alu_op_s4, alu_res_s4, rsp_data_s4;
  logic        alu_z_s4, alu_n_s4, alu_c_s4, alu_v_s4;
  logic [3:0]  rsp_flags_s4, rsp_tag_s4;
  state_t      state_s4;
  logic [35:0] alu_out_s4;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int model_tag = 0;
  logic [40:0] exp_q[$];   // {err, tag[3:0], flags[3:0], data[31:0]}

  // Behavioural ALU: returns {Z,N,C,V,result}
  function automatic logic [35:0] alu_fn(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_PASS_A: r = a;
      OP_PASS_B: r = b;
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_NOT_A:  r = ~a;
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OP_SUB: begin
        s = {1'b0, a} - {1'b0, b}; r = s[31:0]; c = ~s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      OP_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      OP_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      OP_SLTU: r = {31'b0, a < b};
      OP_ADDU: begin
        s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
      end
      default: r = '0;
    endcase
    return {(r == 32'h0), r[31], c, v, r};
  endfunction

  assign alu_out = alu_fn(alu_op[5:0], alu_a, alu_b);
  assign alu_res = alu_out[31:0];
  assign {alu_z, alu_n, alu_c, alu_v} = alu_out[35:32];
  assign alu_out_s4 = alu_fn(alu_op_s4[5:0], alu_a_s4, alu_b_s4);
  assign alu_res_s4 = alu_out_s4[31:0];
  assign {alu_z_s4, alu_n_s4, alu_c_s4, alu_v_s4} = alu_out_s4[35:32];

  alu_op_sequencer #(.SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
    .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .rsp_tag(rsp_tag), .state(state)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(4)) u_dut_s4 (
    .clk(clk), .rst_n(rst_n_s4), .cmd_valid(cmd_valid_s4), .cmd_ready(cmd_ready_s4),
    .cmd_op(cmd_op_s4), .cmd_a(cmd_a_s4), .cmd_b(cmd_b_s4),
    .alu_a(alu_a_s4), .alu_b(alu_b_s4), .alu_op(alu_op_s4), .alu_res(alu_res_s4),
    .alu_z(alu_z_s4), .alu_n(alu_n_s4), .alu_c(alu_c_s4), .alu_v(alu_v_s4),
    .rsp_valid(rsp_valid_s4), .rsp_ready(rsp_ready_s4), .rsp_data(rsp_data_s4),
    .rsp_flags(rsp_flags_s4), .rsp_err(rsp_err_s4), .rsp_tag(rsp_tag_s4), .state(state_s4)
  );

  // Spec-level expectation: legal ops return the ALU answer, illegal ones an
  // error with zero data/flags; every accept consumes the next tag mod 16.
  task automatic model_push(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [35:0] r;
    logic [3:0]  t;
    t = 4'(model_tag);
    if (op <= 6'd13) begin
      r = alu_fn(op, a, b);
      exp_q.push_back({1'b0, t, r});
    end else begin
      exp_q.push_back({1'b1, t, 36'h0});
    end
    model_tag = (model_tag + 1) % 16;
  endtask

  // Driver/monitor: issues one command, observes latency, the ALU drive,
  // the response fields and their behaviour under bp cycles of backpressure.
  task automatic do_cmd(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int bp, output int lat, output logic [40:0] got,
                        output logic [31:0] pre_op, output logic [95:0] drv,
                        output bit drv_stable, output bit hold_ok, output bit idle_after);
    int w;
    lat = -1; got = '0; drv = '0; drv_stable = 1'b1; hold_ok = 1'b1; idle_after = 1'b0;
    pre_op = alu_op;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) return;
    pre_op = alu_op;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    rsp_ready = 1'($urandom_range(0, 1));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) drv = {alu_a, alu_b, alu_op};
      else if (!rsp_valid && ({alu_a, alu_b, alu_op} !== drv)) drv_stable = 1'b0;
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op = 6'($urandom); cmd_a = $urandom; cmd_b = $urandom;
      if (!rsp_valid) rsp_ready = 1'($urandom_range(0, 1));
    end while (!rsp_valid && lat < 40);
    if (!rsp_valid) begin
      lat = 99; cmd_valid = 1'b0; rsp_ready = 1'b0;
      return;
    end
    got = {rsp_err, rsp_tag, rsp_flags, rsp_data};
    rsp_ready = (bp == 0);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (!rsp_valid || cmd_ready || ({rsp_err, rsp_tag, rsp_flags, rsp_data} !== got))
        hold_ok = 1'b0;
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op = 6'($urandom);
      if (i == bp - 1) rsp_ready = 1'b1;
    end
    @(negedge clk);
    idle_after = !rsp_valid && cmd_ready;
    rsp_ready = 1'($urandom_range(0, 1));
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_n_s4 = 1'b0;
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_a = 32'h1234; cmd_b = 32'h5678;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready got %b want 0", cmd_ready); else pass_cnt++;
    chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else pass_cnt++;
    chk_cnt++; if ({alu_a, alu_b, alu_op} !== 96'h0) $display("FAIL reset_alu got %h want 0", {alu_a, alu_b, alu_op}); else pass_cnt++;
    chk_cnt++; if ({rsp_err, rsp_tag, rsp_flags, rsp_data} !== 41'h0) $display("FAIL reset_rsp got %h want 0", {rsp_err, rsp_tag, rsp_flags, rsp_data}); else pass_cnt++;
    chk_cnt++; if (state !== IDLE) $display("FAIL reset_state got %0d want %0d", state, IDLE); else pass_cnt++;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    rst_n = 1'b1; rst_n_s4 = 1'b1;
    @(negedge clk);
    chk_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_release_cmd_ready got %b want 1", cmd_ready); else pass_cnt++;
    chk_cnt++; if (cmd_ready_s4 !== 1'b1) $display("FAIL reset_release_cmd_ready_s4 got %b want 1", cmd_ready_s4); else pass_cnt++;
    model_tag = 0;
    exp_q.delete();
  endtask

  task automatic test_and();
    int lat; logic [40:0] got, exp; logic [31:0] pre_op; logic [95:0] drv; bit ds, ho, ia;
    model_push(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00);
    do_cmd(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 0, lat, got, pre_op, drv, ds, ho, ia);
    exp = exp_q.pop_front();
    chk_cnt++; if (got !== exp) $display("FAIL and_resp got %h want %h", got, exp); else pass_cnt++;
    chk_cnt++; if (got[31:0] !== 32'hF000F000) $display("FAIL and_data got %h want F000F000", got[31:0]); else pass_cnt++;
    chk_cnt++; if (lat !== 3) $display("FAIL and_latency got %0d want 3", lat); else pass_cnt++;
    chk_cnt++; if (drv !== {32'hF0F0F0F0, 32'hFF00FF00, 32'h2}) $display("FAIL and_alu_drive got %h", drv); else pass_cnt++;
    chk_cnt++; if (ia !== 1'b1) $display("FAIL and_idle_after got %b want 1", ia); else pass_cnt++;
  endtask

  task automatic test_addu_carry();
    int lat; logic [40:0] got, exp; logic [31:0] pre_op; logic [95:0] drv; bit ds, ho, ia;
    model_push(OP_ADDU, 32'hFFFFFFFF, 32'h00000001);
    do_cmd(OP_ADDU, 32'hFFFFFFFF, 32'h00000001, 0, lat, got, pre_op, drv, ds, ho, ia);
    exp = exp_q.pop_front();
    chk_cnt++; if (got !== exp) $display("FAIL addu_resp got %h want %h", got, exp); else pass_cnt++;
    chk_cnt++; if (got[32 + FLAG_C] !== 1'b1) $display("FAIL addu_carry got %b want 1", got[32 + FLAG_C]); else pass_cnt++;
    chk_cnt++; if (got[32 + FLAG_Z] !== 1'b1) $display("FAIL addu_zero got %b want 1", got[32 + FLAG_Z]); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int lat; logic [40:0] got, exp; logic [31:0] pre_op; logic [95:0] drv; bit ds, ho, ia;
    logic [5:0] op; logic [31:0] a, b;
    op = 6'($urandom_range(0, 13)); a = $urandom; b = $urandom;
    model_push(op, a, b);
    do_cmd(op, a, b, 5, lat, got, pre_op, drv, ds, ho, ia);
    exp = exp_q.pop_front();
    chk_cnt++; if (got !== exp) $display("FAIL bp_resp got %h want %h", got, exp); else pass_cnt++;
    chk_cnt++; if (ho !== 1'b1) $display("FAIL bp_hold_stable got %b want 1", ho); else pass_cnt++;
    chk_cnt++; if (ia !== 1'b1) $display("FAIL bp_idle_after got %b want 1", ia); else pass_cnt++;
  endtask

  task automatic test_illegal();
    int lat; logic [40:0] got, exp; logic [31:0] pre_op; logic [95:0] drv; bit ds, ho, ia;
    model_push(6'h3F, 32'hDEADBEEF, 32'h12345678);
    do_cmd(6'h3F, 32'hDEADBEEF, 32'h12345678, 2, lat, got, pre_op, drv, ds, ho, ia);
    exp = exp_q.pop_front();
    chk_cnt++; if (got !== exp) $display("FAIL illegal_resp got %h want %h", got, exp); else pass_cnt++;
    chk_cnt++; if (got[40] !== 1'b1) $display("FAIL illegal_err got %b want 1", got[40]); else pass_cnt++;
    chk_cnt++; if (lat !== 1) $display("FAIL illegal_latency got %0d want 1", lat); else pass_cnt++;
    chk_cnt++; if (drv[31:0] !== pre_op) $display("FAIL illegal_alu_op got %h want %h", drv[31:0], pre_op); else pass_cnt++;
    chk_cnt++; if (ho !== 1'b1) $display("FAIL illegal_hold got %b want 1", ho); else pass_cnt++;
  endtask

  task automatic test_random();
    int lat; logic [40:0] got, exp; logic [31:0] pre_op; logic [95:0] drv; bit ds, ho, ia;
    logic [5:0] op; logic [31:0] a, b; int bp;
    for (int n = 0; n < 24; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(14, 63)) : 6'($urandom_range(0, 13));
      a = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFF : $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
      bp = $urandom_range(0, 3);
      model_push(op, a, b);
      do_cmd(op, a, b, bp, lat, got, pre_op, drv, ds, ho, ia);
      exp = exp_q.pop_front();
      chk_cnt++; if (got !== exp) $display("FAIL rand_resp[%0d] op=%h got %h want %h", n, op, got, exp); else pass_cnt++;
      chk_cnt++; if (lat !== ((op <= 6'd13) ? 3 : 1)) $display("FAIL rand_latency[%0d] op=%h got %0d", n, op, lat); else pass_cnt++;
      if (op <= 6'd13) begin
        chk_cnt++; if (drv !== {a, b, 32'(op)} || !ds) $display("FAIL rand_alu_drive[%0d] got %h stable %b", n, drv, ds); else pass_cnt++;
      end else begin
        chk_cnt++; if (drv[31:0] !== pre_op) $display("FAIL rand_alu_op_kept[%0d] got %h want %h", n, drv[31:0], pre_op); else pass_cnt++;
      end
      chk_cnt++; if (ho !== 1'b1 || ia !== 1'b1) $display("FAIL rand_handshake[%0d] hold %b idle %b want 1 1", n, ho, ia); else pass_cnt++;
    end
  endtask

  task automatic test_tag_wrap();
    int lat; logic [40:0] got, exp; logic [31:0] pre_op; logic [95:0] drv; bit ds, ho, ia;
    logic [5:0] op; logic [31:0] a, b; logic [3:0] want_tag;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_tag = 0;
    exp_q.delete();
    for (int i = 0; i < 17; i++) begin
      op = 6'($urandom_range(0, 20)); a = $urandom; b = $urandom;
      want_tag = 4'(i % 16);
      model_push(op, a, b);
      do_cmd(op, a, b, 0, lat, got, pre_op, drv, ds, ho, ia);
      exp = exp_q.pop_front();
      chk_cnt++; if (got[39:36] !== want_tag) $display("FAIL tag_wrap[%0d] got %0d want %0d", i, got[39:36], want_tag); else pass_cnt++;
      chk_cnt++; if (got !== exp) $display("FAIL tag_wrap_resp[%0d] got %h want %h", i, got, exp); else pass_cnt++;
    end
  endtask

  task automatic test_settle4_reset_in_drive();
    int lat, w, rises; logic [5:0] op; logic [31:0] a, b; logic [35:0] want;
    op = OP_SUB; a = $urandom; b = $urandom;
    want = alu_fn(op, a, b);
    w = 0;
    @(negedge clk);
    while (!cmd_ready_s4 && w < 20) begin @(negedge clk); w++; end
    cmd_valid_s4 = 1'b1; cmd_op_s4 = op; cmd_a_s4 = a; cmd_b_s4 = b;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      cmd_valid_s4 = 1'b0;
    end while (!rsp_valid_s4 && lat < 40);
    chk_cnt++; if (lat !== 6) $display("FAIL s4_latency got %0d want 6", lat); else pass_cnt++;
    chk_cnt++; if ({rsp_flags_s4, rsp_data_s4} !== want || rsp_err_s4 !== 1'b0 || rsp_tag_s4 !== 4'd0)
      $display("FAIL s4_resp got %h/%b/%0d want %h/0/0", {rsp_flags_s4, rsp_data_s4}, rsp_err_s4, rsp_tag_s4, want); else pass_cnt++;
    rsp_ready_s4 = 1'b1;
    @(negedge clk);
    rsp_ready_s4 = 1'b0;
    // Second command is abandoned by a reset while the operands settle.
    op = OP_XOR; a = $urandom; b = $urandom;
    cmd_valid_s4 = 1'b1; cmd_op_s4 = op; cmd_a_s4 = a; cmd_b_s4 = b;
    @(negedge clk);
    cmd_valid_s4 = 1'b0;
    @(negedge clk);
    chk_cnt++; if (alu_op_s4 !== 32'(op) || state_s4 !== DRIVE) $display("FAIL s4_in_drive op %h state %0d", alu_op_s4, state_s4); else pass_cnt++;
    rst_n_s4 = 1'b0;
    @(negedge clk);
    chk_cnt++; if ({cmd_ready_s4, rsp_valid_s4, alu_a_s4, alu_b_s4, alu_op_s4} !== 98'h0)
      $display("FAIL s4_reset_alu got %h want 0", {cmd_ready_s4, rsp_valid_s4, alu_a_s4, alu_b_s4, alu_op_s4}); else pass_cnt++;
    chk_cnt++; if ({rsp_err_s4, rsp_tag_s4, rsp_flags_s4, rsp_data_s4} !== 41'h0)
      $display("FAIL s4_reset_rsp got %h want 0", {rsp_err_s4, rsp_tag_s4, rsp_flags_s4, rsp_data_s4}); else pass_cnt++;
    rst_n_s4 = 1'b1;
    rises = 0;
    @(negedge clk);
    chk_cnt++; if (cmd_ready_s4 !== 1'b1) $display("FAIL s4_release_cmd_ready got %b want 1", cmd_ready_s4); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid_s4 === 1'b1) rises++;
      @(negedge clk);
    end
    chk_cnt++; if (rises !== 0) $display("FAIL s4_no_response got %0d cycles of rsp_valid want 0", rises); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    rst_n_s4 = 1'b0; cmd_valid_s4 = 1'b0; cmd_op_s4 = '0; cmd_a_s4 = '0; cmd_b_s4 = '0;
    rsp_ready_s4 = 1'b0;
    test_reset();
    test_and();
    test_addu_carry();
    test_backpressure();
    test_illegal();
    test_random();
    test_tag_wrap();
    test_settle4_reset_in_drive();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
